// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the LCD line formatter.
// Hex digit display is selected at build time with LCD_FMT_HEX_EN.
package lcd_fmt_pkg;

    localparam int unsigned LINE_CHARS = 16;
    localparam int unsigned LINE_BITS  = LINE_CHARS * 8;
    localparam int unsigned BUF_CHARS  = 2 * LINE_CHARS;
    localparam int unsigned BUF_BITS   = BUF_CHARS * 8;
    localparam int unsigned FIELD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNAP,
        ST_FMT,
        ST_PUB
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A_UP  = 8'h41;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_B     = 8'h42;

    localparam logic [LINE_BITS-1:0] BANNER_L1 = "ACCEPTING       ";
    localparam logic [LINE_BITS-1:0] BANNER_L2 = "  INPUT         ";

    // Character at column col of the banner line (col 0 is the leftmost).
    function automatic logic [7:0] banner_char(input logic line2, input logic [3:0] col);
        logic [LINE_BITS-1:0] s;
        s = line2 ? BANNER_L2 : BANNER_L1;
        s = s << {col, 3'b000};
        return s[LINE_BITS-1 -: 8];
    endfunction

endpackage

// File: rtl/lcd_digit_enc.sv
// Maps one digit position of a value field to its ASCII character (space past the field end).
module lcd_digit_enc
    import lcd_fmt_pkg::*;
(
    input  logic [FIELD_W-1:0] value_i,
    input  logic [4:0]         pos_i,
    input  logic [4:0]         width_i,
    input  logic               hex_i,
    output logic [7:0]         char_c
);

    logic [4:0] ndig;
    logic [3:0] sel;
    logic [3:0] nib;

    always_comb begin
        ndig = hex_i ? 5'((width_i + 5'd3) >> 2) : width_i;
        // Digit position counts from the MSB; sel is the digit index from the LSB.
        sel  = 4'(ndig - 5'd1 - pos_i);
        nib  = value_i[{sel[1:0], 2'b00} +: 4];
        char_c = CH_SPACE;
        if (pos_i < ndig) begin
            if (hex_i) begin
                char_c = (nib < 4'd10) ? (CH_ZERO + 8'(nib)) : (CH_A_UP + 8'(nib) - 8'd10);
            end else begin
                char_c = CH_ZERO + 8'(value_i[sel]);
            end
        end
    end

endmodule

// File: rtl/lcd_line_formatter.sv
// Snapshots register-file traffic and formats it into two 16-char LCD lines, one char per cycle.
// Define LCD_FMT_HEX_EN for uppercase hex fields instead of binary.
module lcd_line_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    wa,
    input  logic [ADDR_W-1:0]    raA,
    input  logic [DATA_W-1:0]    wd,
    input  logic [DATA_W-1:0]    rdA,
    input  logic [DATA_W-1:0]    rdB,
    output logic [LINE_BITS-1:0] line1,
    output logic [LINE_BITS-1:0] line2,
    output logic                 lines_valid,
    input  logic                 lines_ready,
    output logic                 busy
);

`ifdef LCD_FMT_HEX_EN
    localparam logic HEX_SEL = 1'b1;
`else
    localparam logic HEX_SEL = 1'b0;
`endif
    localparam logic [4:0] DW5 = 5'(DATA_W);
    localparam logic [4:0] AW5 = 5'(ADDR_W);

    state_e state_q, state_d;
    logic   valid_d, busy_d;
    logic   valid_q, busy_q, force_q;

    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   wa_q, ra_q;
    logic [DATA_W-1:0]   wd_q, rda_q, rdb_q;
    logic [4:0]          idx_q;
    logic [BUF_BITS-1:0] buf_q;
    logic [LINE_BITS-1:0] line1_q, line2_q;

    logic               diff_c;
    logic [3:0]         col;
    logic               on_line2;
    logic               use_enc;
    logic [7:0]         pfx;
    logic [7:0]         enc_char;
    logic [7:0]         ch_c;
    logic [FIELD_W-1:0] enc_val;
    logic [4:0]         enc_pos;
    logic [4:0]         enc_w;

    assign diff_c   = {mode, wa, raA, wd, rdA, rdB} != {mode_q, wa_q, ra_q, wd_q, rda_q, rdb_q};
    assign col      = idx_q[3:0];
    assign on_line2 = idx_q[4];

    // Next state and handshake flags.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: if (force_q || diff_c) state_d = ST_SNAP;
            ST_SNAP: state_d = ST_FMT;
            ST_FMT:  if (idx_q == 5'd31) state_d = ST_PUB;
            ST_PUB: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (lines_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Character for the current buffer index, built from the snapshot.
    always_comb begin
        use_enc = 1'b0;
        pfx     = CH_SPACE;
        enc_val = '0;
        enc_pos = 5'(col);
        enc_w   = DW5;
        case (mode_q)
            2'd0: pfx = banner_char(on_line2, col);
            2'd1, 2'd2: begin
                if (on_line2) begin
                    use_enc = 1'b1;
                    enc_val = (mode_q == 2'd1) ? FIELD_W'(wd_q) : FIELD_W'(rda_q);
                end else if (col < 4'd2) begin
                    if (col == 4'd0) pfx = (mode_q == 2'd1) ? CH_W : CH_A_UP;
                end else begin
                    use_enc = 1'b1;
                    enc_val = (mode_q == 2'd1) ? FIELD_W'(wa_q) : FIELD_W'(ra_q);
                    enc_pos = 5'(col) - 5'd2;
                    enc_w   = AW5;
                end
            end
            default: begin
                if (HEX_SEL && col < 4'd2) begin
                    if (col == 4'd0) pfx = on_line2 ? CH_B : CH_A_UP;
                end else begin
                    use_enc = 1'b1;
                    enc_val = on_line2 ? FIELD_W'(rdb_q) : FIELD_W'(rda_q);
                    enc_pos = HEX_SEL ? (5'(col) - 5'd2) : 5'(col);
                end
            end
        endcase
        ch_c = use_enc ? enc_char : pfx;
    end

    lcd_digit_enc u_enc (
        .value_i (enc_val),
        .pos_i   (enc_pos),
        .width_i (enc_w),
        .hex_i   (HEX_SEL),
        .char_c  (enc_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Snapshot, working buffer and published lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            force_q <= 1'b1;
            mode_q  <= '0;
            wa_q    <= '0;
            ra_q    <= '0;
            wd_q    <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            idx_q   <= '0;
            buf_q   <= {BUF_CHARS{CH_SPACE}};
            line1_q <= {LINE_CHARS{CH_SPACE}};
            line2_q <= {LINE_CHARS{CH_SPACE}};
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            if (state_q == ST_SNAP) begin
                mode_q  <= mode;
                wa_q    <= wa;
                ra_q    <= raA;
                wd_q    <= wd;
                rda_q   <= rdA;
                rdb_q   <= rdB;
                force_q <= 1'b0;
                idx_q   <= '0;
            end
            if (state_q == ST_FMT) begin
                // Char 0 sits at the top of the buffer; ~idx equals 31 - idx.
                buf_q[{~idx_q, 3'b000} +: 8] <= ch_c;
                idx_q <= idx_q + 5'd1;
            end
            if (state_q == ST_PUB && !valid_q) begin
                line1_q <= buf_q[BUF_BITS-1 -: LINE_BITS];
                line2_q <= buf_q[LINE_BITS-1:0];
            end
        end
    end

    assign line1       = line1_q;
    assign line2       = line2_q;
    assign lines_valid = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_line_formatter.sv
// Directed plus randomized bench for lcd_line_formatter with a queue-based line model.
module tb_lcd_line_formatter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 5;

    typedef byte unsigned bq_t[$];

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] wa, raA;
    logic [DATA_W-1:0] wd, rdA, rdB;
    logic [127:0]      line1, line2;
    logic              lines_valid, lines_ready, busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] SPACES = {16{8'h20}};

    lcd_line_formatter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .wa          (wa),
        .raA         (raA),
        .wd          (wd),
        .rdA         (rdA),
        .rdB         (rdB),
        .line1       (line1),
        .line2       (line2),
        .lines_valid (lines_valid),
        .lines_ready (lines_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bq_t digits(input logic [15:0] v, input int w);
        bq_t q;
        string hx = "0123456789ABCDEF";
`ifdef LCD_FMT_HEX_EN
        for (int d = (w + 3) / 4 - 1; d >= 0; d--) q.push_back(hx.getc(int'(v[4*d +: 4])));
`else
        for (int b = w - 1; b >= 0; b--) q.push_back(v[b] ? 8'h31 : 8'h30);
`endif
        return q;
    endfunction

    function automatic logic [127:0] to_line(input bq_t q);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = (i < q.size()) ? q[i] : 8'h20;
        return r;
    endfunction

    task automatic model(output logic [127:0] l1, output logic [127:0] l2);
        bq_t a, b, f;
        case (mode)
            2'd0: begin
                l1 = "ACCEPTING       ";
                l2 = "  INPUT         ";
                return;
            end
            2'd1, 2'd2: begin
                a.push_back(mode == 2'd1 ? 8'h57 : 8'h41);
                a.push_back(8'h20);
                f = digits(16'(mode == 2'd1 ? wa : raA), ADDR_W);
                foreach (f[i]) a.push_back(f[i]);
                b = digits(16'(mode == 2'd1 ? wd : rdA), DATA_W);
            end
            default: begin
`ifdef LCD_FMT_HEX_EN
                a.push_back(8'h41); a.push_back(8'h20);
                b.push_back(8'h42); b.push_back(8'h20);
`endif
                f = digits(16'(rdA), DATA_W);
                foreach (f[i]) a.push_back(f[i]);
                f = digits(16'(rdB), DATA_W);
                foreach (f[i]) b.push_back(f[i]);
            end
        endcase
        l1 = to_line(a);
        l2 = to_line(b);
    endtask

    // Counts rising edges until lines_valid is seen; -1 on timeout.
    task automatic wait_valid(output int e);
        e = 0;
        do begin
            @(negedge clk);
            e++;
        end while (!lines_valid && e < 200);
        if (!lines_valid) e = -1;
    endtask

    // Inputs already applied at a negedge while idle; checks one full update.
    task automatic do_update(input string tag, input int hold);
        int e;
        logic [127:0] x1, x2;
        model(x1, x2);
        wait_valid(e);
        chk({tag, " latency"}, 128'(e), 128'(35));
        chk({tag, " line1"}, line1, x1);
        chk({tag, " line2"}, line2, x2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 128'(lines_valid), 128'(1));
        end
        lines_ready = 1'b1;
        @(negedge clk);
        chk({tag, " valid after xfer"}, 128'(lines_valid), 128'(0));
        chk({tag, " busy after xfer"}, 128'(busy), 128'(0));
        chk({tag, " line1 kept"}, line1, x1);
    endtask

    task automatic no_update(input string tag);
        int seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lines_valid || busy) seen++;
        end
        chk({tag, " no extra update"}, 128'(seen), 128'(0));
    endtask

    initial begin
        logic [127:0] s1, s2, e1, e2;
        logic [1:0] m;
        logic [ADDR_W-1:0] a, r;
        logic [DATA_W-1:0] d, x, y;
        int hold;

        rst_n = 1'b0; lines_ready = 1'b1;
        mode = 2'd0; wa = '0; raA = '0; wd = '0; rdA = '0; rdB = '0;
        repeat (2) @(negedge clk);
        chk("rst line1", line1, SPACES);
        chk("rst line2", line2, SPACES);
        chk("rst valid", 128'(lines_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));

        rst_n = 1'b1;
        do_update("banner", 0);
        chk("banner l1 literal", line1, "ACCEPTING       ");
        chk("banner l2 literal", line2, "  INPUT         ");
        no_update("banner");

        mode = 2'd1; wa = 5'b00011; wd = 16'hA5F0;
        do_update("write", 0);
`ifdef LCD_FMT_HEX_EN
        e1 = "W 03            "; e2 = "A5F0            ";
`else
        e1 = "W 00011         "; e2 = "1010010111110000";
`endif
        chk("write l1 literal", line1, e1);
        chk("write l2 literal", line2, e2);

        mode = 2'd3; rdA = 16'h0001; rdB = 16'hFFFF;
        do_update("both", 0);
`ifdef LCD_FMT_HEX_EN
        e1 = "A 0001          "; e2 = "B FFFF          ";
`else
        e1 = "0000000000000001"; e2 = "1111111111111111";
`endif
        chk("both l1 literal", line1, e1);
        chk("both l2 literal", line2, e2);

        // Back-pressure with a pending input change.
        lines_ready = 1'b0;
        mode = 2'd2; raA = 5'd7; rdA = 16'h1234;
        do_update("bp_first", 0);
        lines_ready = 1'b0;
        mode = 2'd2; rdA = 16'h4321;
        wait_valid(hold);
        chk("bp2 latency", 128'(hold), 128'(35));
        s1 = line1; s2 = line2;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) rdA = 16'hBEEF;
            @(negedge clk);
            chk("bp valid stable", 128'(lines_valid), 128'(1));
            chk("bp line1 stable", line1, s1);
            chk("bp line2 stable", line2, s2);
        end
        lines_ready = 1'b1;
        @(negedge clk);
        chk("bp xfer valid", 128'(lines_valid), 128'(0));
        do_update("bp_pending", 0);
        no_update("bp_pending");

        // Reset mid-FMT: back to banner inputs so only the force flag retriggers.
        mode = 2'd0; wa = '0; raA = '0; wd = '0; rdA = '0; rdB = '0;
        repeat (12) @(negedge clk);
        chk("mid busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid rst line1", line1, SPACES);
        chk("mid rst line2", line2, SPACES);
        chk("mid rst valid", 128'(lines_valid), 128'(0));
        chk("mid rst busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        do_update("forced", 0);
        no_update("forced");

        for (int it = 0; it < 25; it++) begin
            do begin
                m = 2'($urandom);
                a = ADDR_W'($urandom); r = ADDR_W'($urandom);
                d = DATA_W'($urandom); x = DATA_W'($urandom); y = DATA_W'($urandom);
            end while ({m, a, r, d, x, y} == {mode, wa, raA, wd, rdA, rdB});
            mode = m; wa = a; raA = r; wd = d; rdA = x; rdB = y;
            hold = int'($urandom_range(0, 4));
            lines_ready = (hold == 0);
            do_update($sformatf("rand%0d", it), hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
